window_fetcher: RTL and testbench

WINDOW_FETCHER -- requirements
Module: window_fetcher

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/fetch_addr_gen.sv | 25 ++
 rtl/window_fetcher.sv | 212 +++++++++++++++++++++
 tb/tb_window_fetcher.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the sliding-window fetch path.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int WIN_TAPS = 25;
    localparam int MAX_K    = 5;

    // Only an exact 3 selects the small window; everything else is 5x5.
    function automatic logic [2:0] pick_k(input logic [15:0] filter_size);
        return (filter_size == 16'd3) ? 3'd3 : 3'd5;
    endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Combinational pixel address: base + (r+i)*N + (c+j), truncated to ADDR_W.
module fetch_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       r,
    input  logic [15:0]       c,
    input  logic [2:0]        i,
    input  logic [2:0]        j,
    input  logic [15:0]       n,
    output logic [ADDR_W-1:0] addr
);

    logic [16:0] row;
    logic [16:0] col;
    logic [33:0] lin;

    always_comb begin
        row  = {1'b0, r} + 17'(i);
        col  = {1'b0, c} + 17'(j);
        lin  = 34'(row) * 34'(n) + 34'(col);
        addr = ADDR_W'(lin) + base_addr;
    end

endmodule

// File: rtl/window_fetcher.sv
// Fetches KxK pixel windows (K = 3 or 5) over an NxN image, one read at a time.
// Optional stride-2 scanning is enabled by defining WINDOW_FETCHER_STRIDE2_EN.
module window_fetcher
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              filterSize,
    input  logic [15:0]              imgSize,
    input  logic [ADDR_W-1:0]        base_addr,
`ifdef WINDOW_FETCHER_STRIDE2_EN
    input  logic                     stride2,
`endif
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rdata,
    input  logic                     mem_rvalid,
    output logic signed [DATA_W-1:0] window [0:WIN_TAPS-1],
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               fsm_state
);

    // Handshake: a window transfers in any cycle where win_valid and win_ready are both high;
    // window contents and win_valid hold steady until then.

    state_t            st;
    logic [2:0]        k_q;
    logic [15:0]       n_q;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       r_q, c_q;
    logic [2:0]        i_q, j_q;
`ifdef WINDOW_FETCHER_STRIDE2_EN
    logic              stride_q;
`endif

    logic [2:0]        k_new;
    logic              too_small;
    logic [16:0]       step;
    logic              j_last, i_last, taps_done;
    logic [2:0]        nxt_i, nxt_j;
    logic [16:0]       c_adv, r_adv;
    logic              c_last, r_last, frame_last;
    logic [15:0]       nxt_r, nxt_c;
    logic [4:0]        tap_idx;

    logic [ADDR_W-1:0] gen_base;
    logic [15:0]       gen_r, gen_c, gen_n;
    logic [2:0]        gen_i, gen_j;
    logic [ADDR_W-1:0] gen_addr;

    assign fsm_state = st;

    always_comb begin
        k_new     = pick_k(filterSize);
        too_small = imgSize < {13'd0, k_new};
`ifdef WINDOW_FETCHER_STRIDE2_EN
        step      = stride_q ? 17'd2 : 17'd1;
`else
        step      = 17'd1;
`endif
        j_last    = (j_q == k_q - 3'd1);
        i_last    = (i_q == k_q - 3'd1);
        taps_done = j_last && i_last;
        nxt_j     = j_last ? 3'd0 : j_q + 3'd1;
        nxt_i     = j_last ? i_q + 3'd1 : i_q;
        tap_idx   = 5'(i_q) * 5'd5 + 5'(j_q);

        // A position is the last on its axis when one more step would push the window past the edge.
        c_adv      = {1'b0, c_q} + step;
        r_adv      = {1'b0, r_q} + step;
        c_last     = (c_adv + 17'(k_q)) > {1'b0, n_q};
        r_last     = (r_adv + 17'(k_q)) > {1'b0, n_q};
        frame_last = c_last && r_last;
        nxt_c      = c_last ? 16'd0 : c_adv[15:0];
        nxt_r      = c_last ? r_adv[15:0] : r_q;

        // The address generator is fed the coordinates of the read about to be issued.
        gen_base = base_q;
        gen_n    = n_q;
        gen_r    = r_q;
        gen_c    = c_q;
        gen_i    = nxt_i;
        gen_j    = nxt_j;
        case (st)
            IDLE: begin
                gen_base = base_addr;
                gen_n    = imgSize;
                gen_r    = 16'd0;
                gen_c    = 16'd0;
                gen_i    = 3'd0;
                gen_j    = 3'd0;
            end
            EMIT: begin
                gen_r = nxt_r;
                gen_c = nxt_c;
                gen_i = 3'd0;
                gen_j = 3'd0;
            end
            default: ;
        endcase
    end

    fetch_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base_addr (gen_base),
        .r         (gen_r),
        .c         (gen_c),
        .i         (gen_i),
        .j         (gen_j),
        .n         (gen_n),
        .addr      (gen_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            k_q       <= 3'd3;
            n_q       <= 16'd0;
            base_q    <= '0;
            r_q       <= 16'd0;
            c_q       <= 16'd0;
            i_q       <= 3'd0;
            j_q       <= 3'd0;
`ifdef WINDOW_FETCHER_STRIDE2_EN
            stride_q  <= 1'b0;
`endif
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int t = 0; t < WIN_TAPS; t++) window[t] <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        k_q    <= k_new;
                        n_q    <= imgSize;
                        base_q <= base_addr;
                        r_q    <= 16'd0;
                        c_q    <= 16'd0;
                        i_q    <= 3'd0;
                        j_q    <= 3'd0;
`ifdef WINDOW_FETCHER_STRIDE2_EN
                        stride_q <= stride2;
`endif
                        busy   <= 1'b1;
                        // Clearing here keeps taps outside a 3x3 corner at zero all frame.
                        for (int t = 0; t < WIN_TAPS; t++) window[t] <= '0;
                        if (too_small) begin
                            st   <= DONE;
                            done <= 1'b1;
                        end else begin
                            st       <= REQ;
                            mem_rd   <= 1'b1;
                            mem_addr <= gen_addr;
                        end
                    end
                end
                REQ: begin
                    mem_rd <= 1'b0;
                    st     <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        window[tap_idx] <= mem_rdata;
                        if (taps_done) begin
                            i_q       <= 3'd0;
                            j_q       <= 3'd0;
                            win_valid <= 1'b1;
                            st        <= EMIT;
                        end else begin
                            i_q      <= nxt_i;
                            j_q      <= nxt_j;
                            mem_rd   <= 1'b1;
                            mem_addr <= gen_addr;
                            st       <= REQ;
                        end
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (frame_last) begin
                            done <= 1'b1;
                            st   <= DONE;
                        end else begin
                            r_q      <= nxt_r;
                            c_q      <= nxt_c;
                            mem_rd   <= 1'b1;
                            mem_addr <= gen_addr;
                            st       <= REQ;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_fetcher.sv
// Directed bench for window_fetcher: latency-configurable memory model, monitors, assertion checks.
module tb_window_fetcher;
    import cnn_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [15:0]              filterSize = 16'd3;
    logic [15:0]              imgSize = 16'd4;
    logic [ADDR_W-1:0]        base_addr = '0;
`ifdef WINDOW_FETCHER_STRIDE2_EN
    logic                     stride2 = 1'b0;
`endif
    logic                     mem_rd;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_rdata;
    logic                     mem_rvalid;
    logic signed [DATA_W-1:0] window [0:24];
    logic                     win_valid;
    logic                     win_ready = 1'b1;
    logic                     busy;
    logic                     done;
    logic [2:0]               fsm_state;

    int checks = 0;
    int errors = 0;

    window_fetcher #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .filterSize (filterSize),
        .imgSize    (imgSize),
        .base_addr  (base_addr),
`ifdef WINDOW_FETCHER_STRIDE2_EN
        .stride2    (stride2),
`endif
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: data = addr - mem_off + bias, returned lat cycles after the request.
    int                lat = 1;
    int                mem_off = 0;
    int                bias = 0;
    int                pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int                outstanding = 0;
    int                max_out = 0;
    int                ovl_cnt = 0;
    int                rv_cnt = 0;

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = DATA_W'(int'(pend_addr) - mem_off + bias);
                outstanding--;
                rv_cnt++;
            end
        end
        if (mem_rd === 1'b1) begin
            if (outstanding != 0) ovl_cnt++;
            pend_cnt  = lat;
            pend_addr = mem_addr;
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    // Monitor: logs read addresses and accepted windows using pre-edge values.
    int                rd_cnt = 0;
    int                hs_cnt = 0;
    int                done_cnt = 0;
    int                wv_cnt = 0;
    logic [ADDR_W-1:0] addr_log [0:255];
    logic [DATA_W-1:0] win_log [0:63][0:24];

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_rd === 1'b1) begin
                if (rd_cnt < 256) addr_log[rd_cnt] = mem_addr;
                rd_cnt++;
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) begin
                if (hs_cnt < 64)
                    for (int t = 0; t < 25; t++) win_log[hs_cnt][t] = window[t];
                hs_cnt++;
            end
            if (done === 1'b1) done_cnt++;
            if (win_valid === 1'b1) wv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] fs, input logic [15:0] ns, input logic [ADDR_W-1:0] ba);
        @(negedge clk);
        filterSize = fs;
        imgSize    = ns;
        base_addr  = ba;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_rd(input string tag, input int budget, input int target);
        int n = 0;
        while (rd_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reads_reached"}, 32'(rd_cnt == target), 32'd1);
    endtask

    function automatic int zero_count_violations();
        int nz = 0;
        for (int t = 0; t < 25; t++) if (window[t] !== '0) nz++;
        return nz;
    endfunction

    task automatic check_win(input string tag, input int slot, input int r, input int c,
                             input int k, input int n, input int b);
        logic [DATA_W-1:0] e;
        for (int t = 0; t < 25; t++) begin
            if ((t / 5) < k && (t % 5) < k) e = DATA_W'(b + (r + t / 5) * n + (c + t % 5));
            else e = '0;
            check($sformatf("%s_w%0d", tag, t), 32'(win_log[slot][t]), 32'(e));
        end
    endtask

    task automatic check_addrs(input string tag, input int rd0, input int ba, input int k, input int n);
        logic [ADDR_W-1:0] exp_q [$];
        logic [ADDR_W-1:0] e;
        int idx = rd0;
        for (int r = 0; r <= n - k; r++)
            for (int c = 0; c <= n - k; c++)
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        exp_q.push_back(ADDR_W'(ba + (r + i) * n + c + j));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_a%0d", tag, idx - rd0), 32'(addr_log[idx]), 32'(e));
            idx++;
        end
    endtask

    int rd0, hs0, d0, wv0, rv0;
    logic signed [DATA_W-1:0] snap [0:24];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_window_zero", 32'(zero_count_violations()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // K=3, N=4, base 0x100
        lat = 1; mem_off = 'h100; bias = 0;
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt;
        pulse_start(16'd3, 16'd4, 16'h0100);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_rd", 32'(mem_rd), 32'd1);
        check("t1_first_addr", 32'(mem_addr), 32'h100);
        wait_done("t1", 1000, d0);
        check("t1_reads", 32'(rd_cnt - rd0), 32'd36);
        check("t1_windows", 32'(hs_cnt - hs0), 32'd4);
        check("t1_state", 32'(fsm_state), 32'(IDLE));
        check("t1_busy_end", 32'(busy), 32'd0);
        check_win("t1_first", hs0, 0, 0, 3, 4, 0);
        check_win("t1_last", hs0 + 3, 1, 1, 3, 4, 0);
        check_addrs("t1", rd0, 'h100, 3, 4);
        repeat (5) @(negedge clk);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // K=5, N=5, signed data
        mem_off = 'h200; bias = -12;
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt;
        pulse_start(16'd5, 16'd5, 16'h0200);
        wait_done("t2", 1000, d0);
        check("t2_reads", 32'(rd_cnt - rd0), 32'd25);
        check("t2_windows", 32'(hs_cnt - hs0), 32'd1);
        check("t2_last_addr", 32'(addr_log[rd0 + 24]), 32'h218);
        check_win("t2", hs0, 0, 0, 5, 5, -12);

        // Back-pressure: win_ready low for 10 cycles in EMIT
        lat = 2; mem_off = 0; bias = 0; win_ready = 1'b0;
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt;
        pulse_start(16'd3, 16'd3, 16'h0000);
        begin
            int n = 0;
            while (win_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_valid_seen", 32'(win_valid), 32'd1);
        for (int t = 0; t < 25; t++) snap[t] = window[t];
        check("t3_snap_w12", 32'(snap[12]), 32'd8);
        for (int cyc = 0; cyc < 10; cyc++) begin
            int diffs = 0;
            @(negedge clk);
            for (int t = 0; t < 25; t++) if (window[t] !== snap[t]) diffs++;
            check($sformatf("t3_stable_win_c%0d", cyc), 32'(diffs), 32'd0);
            check($sformatf("t3_stable_valid_c%0d", cyc), 32'(win_valid), 32'd1);
            check($sformatf("t3_no_rd_c%0d", cyc), 32'(mem_rd), 32'd0);
        end
        win_ready = 1'b1;
        wait_done("t3", 200, d0);
        check("t3_windows", 32'(hs_cnt - hs0), 32'd1);
        check("t3_reads", 32'(rd_cnt - rd0), 32'd9);
        check_win("t3", hs0, 0, 0, 3, 3, 0);

        // N < K: straight to DONE
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt; wv0 = wv_cnt;
        pulse_start(16'd7, 16'd3, 16'h0300);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_state", 32'(fsm_state), 32'(DONE));
        @(negedge clk);
        check("t4_done_drop", 32'(done), 32'd0);
        check("t4_busy_drop", 32'(busy), 32'd0);
        check("t4_state_idle", 32'(fsm_state), 32'(IDLE));
        check("t4_reads", 32'(rd_cnt - rd0), 32'd0);
        check("t4_windows", 32'(hs_cnt - hs0), 32'd0);
        check("t4_valid_cycles", 32'(wv_cnt - wv0), 32'd0);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset in WAIT after 7 reads, late response afterwards
        lat = 3; mem_off = 'h10; bias = 100;
        rd0 = rd_cnt;
        pulse_start(16'd3, 16'd4, 16'h0010);
        wait_rd("t5", 200, rd0 + 7);
        check("t5_in_wait", 32'(fsm_state), 32'(WAIT));
        check("t5_w0_before", 32'(window[0]), 32'd100);
        rv0 = rv_cnt;
        rst = 1'b1;
        #1;
        check("t5_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_rst_win_valid", 32'(win_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_state", 32'(fsm_state), 32'(IDLE));
        check("t5_rst_window", 32'(zero_count_violations()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_late_rvalid_seen", 32'(rv_cnt - rv0), 32'd1);
        check("t5_late_window", 32'(zero_count_violations()), 32'd0);
        check("t5_late_state", 32'(fsm_state), 32'(IDLE));
        check("t5_late_busy", 32'(busy), 32'd0);
        check("t5_late_mem_rd", 32'(mem_rd), 32'd0);

        // Latency 4, start pulsed mid-frame
        lat = 4; mem_off = 'h40; bias = 0;
        rd0 = rd_cnt; hs0 = hs_cnt; d0 = done_cnt;
        pulse_start(16'd3, 16'd4, 16'h0040);
        wait_rd("t6", 200, rd0 + 5);
        @(negedge clk);
        filterSize = 16'd5;
        imgSize    = 16'd9;
        base_addr  = 16'h0900;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6", 2000, d0);
        check("t6_reads", 32'(rd_cnt - rd0), 32'd36);
        check("t6_windows", 32'(hs_cnt - hs0), 32'd4);
        check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t6_overlap", 32'(ovl_cnt), 32'd0);
        check("t6_max_outstanding", 32'(max_out), 32'd1);
        check_win("t6_first", hs0, 0, 0, 3, 4, 0);
        check_win("t6_last", hs0 + 3, 1, 1, 3, 4, 0);
        check_addrs("t6", rd0, 'h40, 3, 4);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
